// File: rtl/ula_pkg.sv
// Shared opcodes, FSM state encoding and width helpers
// for the sequential ALU.
package ula_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_DIV = 4'b0111;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  function automatic int res_w(int w);
    return 2 * w;
  endfunction

  function automatic int cnt_w(int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/ula_seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider
// sharing one WIDTH+1 bit adder/subtractor.
module ula_seq_muldiv
  import ula_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_div,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  busy,
  output logic                  done,
  output logic [2*WIDTH-1:0]    result
);

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] hi, lo, opnd;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [CW-1:0]    cnt;
  logic             busy_q, div_q;

  logic [WIDTH:0]   sx, sy, sum, sel;
  logic [WIDTH+1:0] add_full;
  logic             cout;

  // hi:lo is the product accumulator or the remainder:quotient pair
  always_comb begin
    sx       = div_q ? {hi, lo[WIDTH-1]} : {1'b0, hi};
    sy       = {1'b0, opnd};
    add_full = {1'b0, sx}
             + {1'b0, (div_q ? ~sy : sy)}
             + (WIDTH+2)'(div_q);
    sum      = add_full[WIDTH:0];
    cout     = add_full[WIDTH+1];
    sel      = '0;
    if (div_q) begin
      hi_n = cout ? sum[WIDTH-1:0] : sx[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], cout};
    end else begin
      sel  = lo[0] ? sum : sx;
      hi_n = sel[WIDTH:1];
      lo_n = {sel[0], lo[WIDTH-1:1]};
    end
  end

  assign result = {hi_n, lo_n};
  assign done   = busy_q && (cnt == CW'(1));
  assign busy   = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
    end else if (start) begin
      hi     <= '0;
      lo     <= is_div ? a : b;
      opnd   <= is_div ? b : a;
      cnt    <= CW'(WIDTH);
      busy_q <= 1'b1;
      div_q  <= is_div;
    end else if (busy_q) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Handshaked ALU: single-cycle logic/add/sub, iterative
// mul/div, registered result and flags.
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OP_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [OP_W-1:0]     op,
  output logic                out_valid,
  output logic [2*WIDTH-1:0]  out_ula,
  output logic                sinal,
  output logic                zero,
  output logic                div_zero
);

  localparam int RW = res_w(WIDTH);

  state_t state;

  logic is_add, is_sub, is_mul, is_and;
  logic is_or, is_xor, is_div;
  logic accept, iter;
  logic [RW-1:0] s_res;
  logic s_sinal, s_dz;

  logic md_busy, md_done;
  logic [RW-1:0] md_res;

  assign is_add = op == OP_W'(OP_ADD);
  assign is_sub = op == OP_W'(OP_SUB);
  assign is_mul = op == OP_W'(OP_MUL);
  assign is_and = op == OP_W'(OP_AND);
  assign is_or  = op == OP_W'(OP_OR);
  assign is_xor = op == OP_W'(OP_XOR);
  assign is_div = op == OP_W'(OP_DIV);

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign iter     = is_mul || (is_div && (b != '0));

  always_comb begin
    s_res   = '0;
    s_sinal = 1'b0;
    s_dz    = 1'b0;
    unique case (1'b1)
      is_add: s_res = RW'({1'b0, a} + {1'b0, b});
      is_sub: begin
        s_sinal = a < b;
        s_res   = RW'((a < b) ? b - a : a - b);
      end
      is_and: s_res = RW'(a & b);
      is_or:  s_res = RW'(a | b);
      is_xor: s_res = RW'(a ^ b);
      // only reached when b is zero; b!=0 takes the iterative path
      is_div: begin
        s_dz  = 1'b1;
        s_res = {a, {WIDTH{1'b1}}};
      end
      default: s_res = '0;
    endcase
  end

  ula_seq_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (accept && iter),
    .is_div(is_div),
    .a     (a),
    .b     (b),
    .busy  (md_busy),
    .done  (md_done),
    .result(md_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_ula   <= '0;
      sinal     <= 1'b0;
      zero      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (iter) begin
              state <= BUSY;
            end else begin
              out_valid <= 1'b1;
              out_ula   <= s_res;
              sinal     <= s_sinal;
              div_zero  <= s_dz;
              zero      <= (s_res == '0);
            end
          end
        end
        BUSY: begin
          if (md_done) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            out_ula   <= md_res;
            sinal     <= 1'b0;
            div_zero  <= 1'b0;
            zero      <= (md_res == '0);
          end else if (!md_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq at WIDTH=4: directed vectors
// pushed at issue, popped by a monitor on out_valid.
module tb_ula_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a, b, op;
  logic       out_valid;
  logic [7:0] out_ula;
  logic       sinal, zero, div_zero;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [7:0] ula;
    logic       s;
    logic       z;
    logic       d;
  } exp_t;

  exp_t q[$];

  ula_seq #(
    .WIDTH(4),
    .OP_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ula  (out_ula),
    .sinal    (sinal),
    .zero     (zero),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("out_cycle", cyc, e.cyc);
        chk("out_ula", int'(out_ula), int'(e.ula));
        chk("sinal", int'(sinal), int'(e.s));
        chk("zero", int'(zero), int'(e.z));
        chk("div_zero", int'(div_zero), int'(e.d));
      end
    end
  end

  task automatic issue(logic [3:0] o, logic [3:0] x,
                       logic [3:0] y, int lat,
                       logic [7:0] e, logic s,
                       logic z, logic d);
    int t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("issue_ready", int'(in_ready), 1);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    q.push_back('{cyc + lat, e, s, z, d});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int t;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    op       = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_ula", int'(out_ula), 0);
    chk("rst_flags", int'({sinal, zero, div_zero}), 0);

    issue(4'b0001, 4'd9, 4'd8, 1, 8'h11, 0, 0, 0);
    chk("add_in_ready_c1", int'(in_ready), 1);

    issue(4'b0010, 4'd3, 4'd5, 1, 8'h02, 1, 0, 0);
    issue(4'b0010, 4'd5, 4'd5, 1, 8'h00, 0, 1, 0);

    // MUL 15*15 with a competing request held while busy
    issue(4'b0011, 4'd15, 4'd15, 5, 8'hE1, 0, 0, 0);
    op       = 4'b0001;
    a        = 4'd1;
    b        = 4'd1;
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("mul_busy_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mul_c5_ready", int'(in_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("mul_ula_holds", int'(out_ula), 8'hE1);

    issue(4'b0111, 4'd13, 4'd4, 5, 8'h13, 0, 0, 0);
    issue(4'b0111, 4'd7, 4'd0, 1, 8'h7F, 0, 0, 1);
    chk("div0_no_busy", int'(in_ready), 1);

    issue(4'b0100, 4'hC, 4'hA, 1, 8'h08, 0, 0, 0);
    issue(4'b0101, 4'hC, 4'hA, 1, 8'h0E, 0, 0, 0);
    issue(4'b0110, 4'hC, 4'hA, 1, 8'h06, 0, 0, 0);
    issue(4'b1111, 4'hC, 4'hA, 1, 8'h00, 0, 1, 0);

    // reset in c2 of a MUL aborts it
    issue(4'b0010, 4'd1, 4'd6, 1, 8'h05, 1, 0, 0);
    issue(4'b0011, 4'd3, 4'd3, 5, 8'h09, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(q.pop_back());
    chk("rst_mid_in_ready", int'(in_ready), 1);
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_out_ula", int'(out_ula), 0);
    chk("rst_mid_flags", int'({sinal, zero, div_zero}), 0);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid_no_result", int'(out_ula), 0);

    issue(4'b0001, 4'd2, 4'd3, 1, 8'h05, 0, 0, 0);

    t = 0;
    while (q.size() > 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", q.size(), 0);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Parametrised, handshaked successor to the processor's 4-bit ALU. The datapath width is generic.
- Logic, add and subtract ops complete in one cycle.
- Multiply (shift-add) and divide (restoring) are iterative, taking WIDTH cycles.
- Produces registered result and flags.
- Sits between the register file and the accumulator/writeback path of the processor core.

Parameters:
WIDTH, 4, operand width in bits (>=2); result width is 2*WIDTH
OP_W, 4, opcode width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept; transfer when in_valid && in_ready at a rising edge
a  in  WIDTH  operand A, unsigned
b  in  WIDTH  operand B, unsigned
op  in  OP_W  operation select
out_valid  out  1  one-cycle pulse: out_ula/flags hold a new result
out_ula  out  2*WIDTH  result
sinal  out  1  subtraction sign: 1 when a<b
zero  out  1  out_ula == 0
div_zero  out  1  divide with b==0

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State is IDLE.
  - in_ready=1 after reset.
  - out_valid=0, out_ula=0, sinal=0, zero=0, div_zero=0.
  - Reset mid-iteration aborts the operation; no out_valid is produced for it.
- Opcodes (4'b):
  - 0001 ADD: out_ula = zero-extended a+b, carry in bit WIDTH.
  - 0010 SUB: out_ula = |a-b| zero-extended; sinal=1 iff a<b.
  - 0011 MUL: iterative, out_ula = a*b (full 2*WIDTH).
  - 0100 AND, 0101 OR, 0110 XOR: bitwise, zero-extended.
  - 0111 DIV: iterative; out_ula = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
  - Any other code: out_ula=0, single-cycle, out_valid still pulses.
- Flag scope:
  - sinal and div_zero are 0 for every op other than their own.
  - zero is always computed from the final out_ula.
  - All flags update only together with out_ula, i.e. in the out_valid cycle. They hold between results.
- FSM states: IDLE, BUSY.
- IDLE:
  - in_ready=1.
  - On accept of a single-cycle op, the result is registered at that edge. out_valid=1 in the next cycle and the state stays IDLE, giving one-per-cycle throughput.
  - On accept of MUL, or DIV with b!=0, operands are loaded at the accept edge, the iteration counter is set to WIDTH, and the FSM goes to BUSY.
- BUSY:
  - in_ready=0; in_valid is ignored and its operands are never captured.
  - One iteration per edge; the counter decrements.
  - At the edge where the counter reaches 0, the result and flags are registered and the FSM returns to IDLE.
  - The result cycle has out_valid=1 and in_ready=1. A new accept in that cycle is legal.
- Latency, with the accept in cycle c0:
  - single-cycle ops: out_valid in c1.
  - MUL/DIV: in_ready=0 in c1..cWIDTH; out_valid in c(WIDTH+1).
- DIV with b==0: treated as single-cycle.
  - Quotient = all ones, remainder = a, div_zero=1.
  - out_valid in c1; the FSM never enters BUSY.
- out_ula holds its last value until the next result; out_valid is never held more than one cycle.
- No backpressure on the output: the consumer must take the result in its out_valid cycle.
- Operand inputs are sampled only at the accept edge. Changes to a/b/op while BUSY have no effect.

Decomposition:
- Shared package ula_pkg holds:
  - opcode localparams OP_ADD..OP_DIV;
  - the state encoding IDLE/BUSY;
  - the derived widths: result width 2*WIDTH and counter width $clog2(WIDTH+1).
- One sub-module is natural: ula_seq_muldiv.
  - Holds the iterative shift-add/restoring-divide datapath, sharing one WIDTH+1-bit adder/subtractor.
  - Interface: start, is_div, a, b, busy, done, result.
- The top level keeps the handshake FSM, the single-cycle ops and the output registers.

Test Plan:
- WIDTH=4, ADD a=9, b=8, accept c0 -> c1: out_valid=1, out_ula=0x11, zero=0, sinal=0; in_ready stays 1.
- SUB a=3, b=5 -> c1: out_ula=0x02, sinal=1. Then SUB 5,5 in the next cycle -> out_ula=0, zero=1, sinal=0.
- MUL a=15, b=15 -> in_ready=0 in c1..c4; out_valid only in c5 with out_ula=0xE1. A second in_valid with a=1, b=1, held during c1..c4, is not accepted and out_ula does not change to its result.
- DIV a=13, b=4 -> c5: out_ula=0x13 (rem 1, quot 3), div_zero=0. DIV a=7, b=0 -> c1: out_ula=0x7F, div_zero=1, no BUSY.
- Back-to-back AND 0xC&0xA, OR, XOR in c0, c1, c2 -> out_valid in c1, c2, c3 with 0x08, 0x0E, 0x06. Opcode 1111 -> out_ula=0, out_valid=1.
- Reset: assert rst in c2 of a MUL -> next cycle state IDLE, in_ready=1, all outputs 0, no out_valid ever for that MUL. A new ADD after reset completes normally.
